// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART-to-DDR FIFO write side.
//   DATA_WIDTH_DEF : default FIFO word width
//   PAD_BYTE_DEF   : default fill byte for padded (flushed / timed-out) words
//   pack_state_t   : assembly-side state of the word packer
package uart_fifo_pkg;
    localparam int         DATA_WIDTH_DEF = 32;
    localparam logic [7:0] PAD_BYTE_DEF   = 8'h00;

    typedef enum logic {
        EMPTY   = 1'b0,
        FILLING = 1'b1
    } pack_state_t;
endpackage

// File: rtl/uart_word_packer_idle_timer.sv
// Idle timer for the word packer.
//   wclk, wrst : write-domain clock, synchronous active-high reset
//   clear      : restart the count from zero
//   run        : count this cycle (a partial word is waiting, no byte arriving)
//   expire     : combinational; high on the run cycle that ends the idle window
// TIMEOUT_CYCLES=0 disables the timer entirely.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic wclk,
    input  logic wrst,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
            logic [TW-1:0] cnt;

            assign expire = run && (cnt == LAST);

            always_ff @(posedge wclk) begin
                if (wrst || clear || expire)
                    cnt <= '0;
                else if (run)
                    cnt <= cnt + 1'b1;
            end
        end
    endgenerate
endmodule

// File: rtl/uart_word_packer.sv
// Packs UART RX bytes little-endian into DATA_WIDTH words and writes them
// into the async FIFO, absorbing full stalls with a one-word pending buffer.
//   wclk, wrst        : write clock, synchronous active-high reset
//   rx_valid, rx_data : byte strobe and byte (no backpressure)
//   flush             : emit the partial word now (padded with PAD_BYTE)
//   full              : FIFO full from the write-pointer stage
//   w_en, wdata       : FIFO write request, held until w_en && !full
//   partial           : current w_en word was padded
//   overflow          : sticky, a completed word was dropped
//   word_cnt          : words accepted (wraps)
//   drop_cnt          : words dropped (saturates)
module uart_word_packer
    import uart_fifo_pkg::*;
#(
    parameter int         DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] PAD_BYTE       = PAD_BYTE_DEF,
    parameter int         CNT_WIDTH      = 16
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  flush,
    input  logic                  full,
    output logic                  w_en,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  partial,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int KW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BPW - 1);

    pack_state_t          state, state_nxt;
    logic [KW-1:0]        k, k_nxt;
    logic [BPW-1:0][7:0]  asm_q, asm_nxt, word;
    logic                 complete, word_partial, flush_eff, last_byte;
    logic                 expire, timer_clear, timer_run, accept;

    assign accept      = w_en && !full;
    assign timer_clear = rx_valid || (k == '0);
    assign timer_run   = (k != '0) && !rx_valid;

    idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .wclk   (wclk),
        .wrst   (wrst),
        .clear  (timer_clear),
        .run    (timer_run),
        .expire (expire)
    );

    always_comb begin
        state_nxt    = state;
        k_nxt        = k;
        asm_nxt      = asm_q;
        word         = asm_q;
        last_byte    = rx_valid && (k == K_LAST);
        // flush is meaningless with nothing held and nothing arriving
        flush_eff    = flush && ((k != '0) || rx_valid);
        complete     = last_byte || flush_eff || expire;
        word_partial = complete && !last_byte;

        if (rx_valid)
            asm_nxt[k] = rx_data;

        // bytes not yet received this word are filled with the pad value
        for (int b = 0; b < BPW; b++) begin
            if ((KW'(b) > k) || ((KW'(b) == k) && !rx_valid))
                word[b] = PAD_BYTE;
            else
                word[b] = asm_nxt[b];
        end

        if (complete)
            k_nxt = '0;
        else if (rx_valid)
            k_nxt = k + 1'b1;

        case (state)
            EMPTY:   if (rx_valid && !complete) state_nxt = FILLING;
            FILLING: if (complete)              state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            k        <= '0;
            asm_q    <= '0;
            w_en     <= 1'b0;
            wdata    <= '0;
            partial  <= 1'b0;
            overflow <= 1'b0;
            word_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            k     <= k_nxt;
            asm_q <= asm_nxt;
            if (accept)
                word_cnt <= word_cnt + 1'b1;
            // pending slot is free if empty or draining on this same edge
            if (complete && (!w_en || accept)) begin
                w_en    <= 1'b1;
                wdata   <= word;
                partial <= word_partial;
            end else begin
                if (complete) begin
                    overflow <= 1'b1;
                    if (drop_cnt != '1)
                        drop_cnt <= drop_cnt + 1'b1;
                end
                if (accept) begin
                    w_en    <= 1'b0;
                    partial <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_word_packer.sv
// Self-checking bench for uart_word_packer (32-bit words, 16-cycle timeout).
// Accepted FIFO writes are captured at the falling edge and compared against
// words built directly from the byte stream the bench sent.
module tb_uart_word_packer;
    logic        wclk = 1'b0;
    logic        wrst, rx_valid, flush, full;
    logic [7:0]  rx_data;
    logic        w_en, partial, overflow;
    logic [31:0] wdata;
    logic [15:0] word_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;

    uart_word_packer #(
        .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .PAD_BYTE(8'h00), .CNT_WIDTH(16)
    ) dut (
        .wclk(wclk), .wrst(wrst), .rx_valid(rx_valid), .rx_data(rx_data),
        .flush(flush), .full(full), .w_en(w_en), .wdata(wdata),
        .partial(partial), .overflow(overflow), .word_cnt(word_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // write monitor: words the FIFO actually takes, plus hold-stability check
    logic [31:0] acc_q[$];
    bit          accp_q[$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;

    always @(negedge wclk) begin
        if (prev_stall && w_en === 1'b1 && wrst === 1'b0)
            chk("hold_stable", wdata, prev_data);
        prev_stall = (w_en === 1'b1) && (full === 1'b1) && (wrst === 1'b0);
        prev_data  = wdata;
        if (wrst === 1'b0 && w_en === 1'b1 && full === 1'b0) begin
            acc_q.push_back(wdata);
            accp_q.push_back(partial);
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        wrst = 1'b1; rx_valid = 1'b0; flush = 1'b0; full = 1'b0;
        repeat (2) tick();
        wrst = 1'b0;
        acc_q.delete();
        accp_q.delete();
    endtask

    task automatic drive_full();
        // never two full cycles in a row, so the pending word always drains
        full = !full && ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_b[$];
        logic [31:0] ew;
        int gap;

        wrst = 1'b1; rx_valid = 1'b0; flush = 1'b0; full = 1'b0; rx_data = 8'h00;

        // 1: reset held over byte traffic
        repeat (3) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            tick();
        end
        wrst = 1'b0; rx_valid = 1'b0;
        chk("rst_w_en", w_en, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_partial", partial, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        acc_q.delete(); accp_q.delete();

        // 2: plain pack, first word after reset begins at byte 0
        send(8'h11); send(8'h22); send(8'h33);
        chk("pack_no_early", w_en, 0);
        send(8'h44);
        chk("pack_w_en", w_en, 1);
        chk("pack_wdata", wdata, 32'h44332211);
        chk("pack_partial", partial, 0);
        tick();
        chk("pack_w_en_drop", w_en, 0);
        chk("pack_word_cnt", word_cnt, 1);
        repeat (3) tick();
        chk("pack_one_write", acc_q.size(), 1);

        // 3: stall with overflow
        do_reset();
        full = 1'b1;
        for (int i = 1; i <= 4; i++) send(8'(i));
        chk("stall_w_en", w_en, 1);
        chk("stall_wdata", wdata, 32'h04030201);
        chk("stall_no_ovf", overflow, 0);
        for (int i = 5; i <= 8; i++) send(8'(i));
        chk("stall_overflow", overflow, 1);
        chk("stall_drop_cnt", drop_cnt, 1);
        chk("stall_wdata_kept", wdata, 32'h04030201);
        chk("stall_word_cnt0", word_cnt, 0);
        full = 1'b0;
        tick();
        chk("stall_released", w_en, 0);
        chk("stall_word_cnt", word_cnt, 1);
        repeat (2) tick();
        chk("stall_one_write", acc_q.size(), 1);
        if (acc_q.size() > 0) chk("stall_written", acc_q[0], 32'h04030201);
        chk("stall_ovf_sticky", overflow, 1);

        // 4: idle timeout pads the partial word
        do_reset();
        send(8'hAA); send(8'hBB);
        repeat (15) tick();
        chk("tmo_not_yet", w_en, 0);
        tick();
        chk("tmo_w_en", w_en, 1);
        chk("tmo_wdata", wdata, 32'h0000BBAA);
        chk("tmo_partial", partial, 1);
        tick();
        chk("tmo_word_cnt", word_cnt, 1);

        // 5: flush with a byte, flush at k=0, flush of a single byte
        do_reset();
        send(8'h11); send(8'h22); send(8'h33);
        rx_valid = 1'b1; rx_data = 8'hCC; flush = 1'b1;
        tick();
        rx_valid = 1'b0; flush = 1'b0;
        chk("flb_w_en", w_en, 1);
        chk("flb_wdata", wdata, 32'hCC332211);
        chk("flb_partial", partial, 0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        chk("fl0_w_en", w_en, 0);
        chk("fl0_word_cnt", word_cnt, 1);
        chk("fl0_writes", acc_q.size(), 1);
        send(8'h55);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl1_w_en", w_en, 1);
        chk("fl1_wdata", wdata, 32'h00000055);
        chk("fl1_partial", partial, 1);
        tick();
        chk("fl1_word_cnt", word_cnt, 2);

        // 6: random stream with intermittent full
        do_reset();
        for (int i = 0; i < 400; i++) begin
            exp_b.push_back(8'($urandom));
            rx_valid = 1'b1;
            rx_data  = exp_b[i];
            drive_full();
            tick();
            rx_valid = 1'b0;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                drive_full();
                tick();
            end
        end
        full = 1'b0;
        repeat (5) tick();
        chk("rnd_writes", acc_q.size(), 100);
        for (int i = 0; i < 100 && i < acc_q.size(); i++) begin
            ew = {exp_b[4*i+3], exp_b[4*i+2], exp_b[4*i+1], exp_b[4*i]};
            chk($sformatf("rnd_word%0d", i), acc_q[i], ew);
            chk($sformatf("rnd_part%0d", i), accp_q[i], 0);
        end
        chk("rnd_word_cnt", word_cnt, 100);
        chk("rnd_drop_cnt", drop_cnt, 0);
        chk("rnd_overflow", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
